// File: rtl/fetch_issue_queue.sv
// Fetch/issue pair queue feeding the even/odd pipes: fetches aligned pairs, holds the head under RAW stall, flushes on taken branch.
// Optional perf counters enabled by defining FETCH_ISSUE_PERF_EN.
module fetch_issue_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h4020_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [7:0]               imem_addr,
  output logic                     imem_rd,
  input  logic [0:63]              imem_data,
  input  logic                     stall_odd_raw,
  input  logic                     stall_even_raw,
  input  logic                     branch_taken,
  input  logic [7:0]               pc_wb,
  output logic [0:31]              instr0,
  output logic [0:31]              instr1,
  output logic                     instr0_valid,
  output logic                     instr1_valid,
  output logic [7:0]               pc_out,
  output logic                     issue_valid,
  output logic                     issue_fire,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_ISSUE_PERF_EN
  ,
  output logic [15:0]              perf_stall_cycles,
  output logic [15:0]              perf_flush_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]       pc_q [DEPTH];
  logic [0:31]      i0_q [DEPTH];
  logic [0:31]      i1_q [DEPTH];
  logic [DEPTH-1:0] v0_q;
  logic [DEPTH-1:0] v1_q;

  logic [7:0]    fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic stall;
  logic full;
  logic push;
  logic pop;

  always_comb begin
    stall       = stall_odd_raw | stall_even_raw;
    full        = (count == CW'(DEPTH));
    imem_rd     = ~full & ~branch_taken & ~reset;
    imem_addr   = {fetch_pc[7:1], 1'b0};
    issue_valid = (count != '0);
    issue_fire  = issue_valid & ~stall & ~branch_taken;
    push        = imem_rd;
    pop         = issue_fire;
    q_count     = count;
  end

  // Head presentation: an empty queue or an invalid slot reads as NOP.
  always_comb begin
    instr0       = NOP_INSTR;
    instr1       = NOP_INSTR;
    instr0_valid = 1'b0;
    instr1_valid = 1'b0;
    pc_out       = '0;
    if (issue_valid) begin
      pc_out       = pc_q[rd_ptr];
      instr0_valid = v0_q[rd_ptr];
      instr1_valid = v1_q[rd_ptr];
      if (v0_q[rd_ptr]) instr0 = i0_q[rd_ptr];
      if (v1_q[rd_ptr]) instr1 = i1_q[rd_ptr];
    end
  end

  // Payload storage needs no reset; its valid bits below gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= imem_addr;
      i0_q[wr_ptr] <= imem_data[0:31];
      i1_q[wr_ptr] <= imem_data[32:63];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
    end else if (branch_taken) begin
      fetch_pc <= pc_wb;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      v0_q     <= '0;
      v1_q     <= '0;
    end else begin
      if (push) begin
        v0_q[wr_ptr] <= ~fetch_pc[0];
        v1_q[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + PW'(1);
        fetch_pc     <= imem_addr + 8'd2;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_ISSUE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (issue_valid && stall && !branch_taken && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
      if (branch_taken && perf_flush_count != '1)
        perf_flush_count <= perf_flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
- Instruction fetch and issue buffer that sits directly upstream of the decode/RF stage feeding the even and odd pipes.
- Fetches aligned instruction pairs from instruction memory and queues them.
- Presents the head pair for issue and holds it while either pipe reports a RAW stall.
- On a taken branch from the odd pipe, flushes the queue and redirects fetch to the branch target.

Parameters:
- DEPTH, 4, number of pair entries in the queue (power of two, ≥2)
- NOP_INSTR, 32'h4020_0000, encoding driven into an invalid slot

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- imem_addr  out  8  fetch address; word index with bit 0 forced to 0
- imem_rd  out  1  fetch request this cycle
- imem_data  in  [0:63]  pair read at imem_addr, combinational same-cycle; [0:31] is slot0, [32:63] is slot1
- stall_odd_raw  in  1  odd-pipe RAW stall
- stall_even_raw  in  1  even-pipe RAW stall
- branch_taken  in  1  odd pipe resolved a taken branch
- pc_wb  in  8  branch target word index
- instr0  out  [0:31]  head slot0, or NOP_INSTR if invalid
- instr1  out  [0:31]  head slot1
- instr0_valid  out  1  slot0 valid
- instr1_valid  out  1  slot1 valid
- pc_out  out  8  word index of head slot0 (always even)
- issue_valid  out  1  queue non-empty
- issue_fire  out  1  issue_valid & ~stall & ~branch_taken
- q_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage per entry: pc, instr0, instr1, v0, v1. Read and write pointers wrap modulo DEPTH. Occupancy is tracked by a counter.
- Reset (async, active-high) clears:
  - fetch_pc, pointers and count to 0
  - all v0/v1 to 0
  - imem_rd, issue_valid and issue_fire read 0 while reset is asserted
- stall = stall_odd_raw | stall_even_raw.
- Fetch:
  - imem_rd = (count < DEPTH) & ~branch_taken & ~reset
  - imem_addr = {fetch_pc[7:1], 1'b0}
  - On imem_rd, the entry at wr_ptr captures imem_data, pc = imem_addr, v0 = ~fetch_pc[0], v1 = 1.
  - fetch_pc advances to imem_addr + 2, modulo 256 (254 wraps to 0).
- Full queue: when count == DEPTH, no fetch that cycle, even if a pop occurs. Fetch resumes the following cycle.
- Issue:
  - Outputs are combinational from the head entry.
  - When count == 0: instr0/instr1 = NOP_INSTR, valids = 0, pc_out = 0.
  - Pop on issue_fire. The head is held unchanged while stalled.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Latency: a pair fetched in cycle N is visible at the outputs in cycle N+1 at the earliest.
- Branch (branch_taken = 1) has priority over fetch and pop. At the clock edge:
  - count and pointers go to 0, and all entry valids clear
  - fetch_pc <= pc_wb
  - no push or pop occurs
  - next cycle: issue_valid = 0, fetch restarts at {pc_wb[7:1], 0}
- Odd branch target: the first refetched pair has v0 = 0, and instr0 reads NOP_INSTR. Subsequent pairs are fully valid.
- Branch asserted while the queue is empty or full: same flush behaviour.
- Stall and branch_taken together: the branch wins and the head is discarded.
- Twin-instruction kill is handled downstream; this block does not inspect branch_kill.

Optional Feature:
- Macro: FETCH_ISSUE_PERF_EN. When defined, the block adds two output ports, both 16 bits, saturating at 16'hFFFF, and cleared by reset:
  - perf_stall_cycles: counts cycles with issue_valid & stall & ~branch_taken
  - perf_flush_count: counts cycles with branch_taken
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset release, imem returns pair k = {32'h1000_0000+2k, 32'h1000_0001+2k}, no stalls:
  - imem_addr steps 0, 2, 4, ...
  - the cycle after the first fetch: issue_valid = 1, pc_out = 0, instr0 = 32'h1000_0000
  - issue_fire every cycle thereafter
- Hold stall_even_raw = 1 for 6 cycles from reset release:
  - q_count reaches 4 and stays, imem_rd = 0
  - the head stays pc_out = 0
  - after release, pc_out advances 0, 2, 4 one per cycle and fetch resumes
- With the queue full, pulse branch_taken with pc_wb = 8'd37:
  - next cycle: issue_valid = 0, q_count = 0, imem_addr = 36
  - the following cycle: pc_out = 36, instr0_valid = 0, instr0 = 32'h4020_0000, instr1_valid = 1
- Force pc_wb = 8'd254 via a branch, no stalls: fetched addresses are 254, 0, 2, and pc_out wraps to 0.
- branch_taken together with stall_odd_raw = 1 and a non-empty queue: the queue flushes and issue_fire = 0 in that cycle.
- Assert reset mid-stream with q_count = 3: outputs clear immediately (asynchronous), without waiting for a clock edge. With FETCH_ISSUE_PERF_EN defined, perf counters read 0 after reset and count 5 after a 5-cycle stall.
